pipe_sorter: RTL and testbench

// - Streaming frame sorter: takes one unsigned sample per clock, groups consecutive samples into

---
 rtl/pipe_sorter_pkg.sv | 31 +++
 rtl/pipe_sorter_sort_layer.sv | 27 ++
 rtl/pipe_sorter.sv | 111 +++++++++++
 tb/tb_pipe_sorter.sv | 112 +++++++++++
 4 files changed

// File: rtl/pipe_sorter_pkg.sv
// Shared types and helpers for the streaming frame sorter.
//   DATA_W  : sample width (unsigned compare)
//   N       : frame length, even and >= 2; also the number of sort layers
//   data_t  : one sample
//   frame_t : one frame, element 0 in the least significant slot
//   cmp_swap: returns {lo, hi} of two samples
package pipe_sorter_pkg;
  localparam int DATA_W = 8;
  localparam int N      = 8;
  localparam int CNT_W  = $clog2(N);

  typedef logic [DATA_W-1:0] data_t;
  typedef data_t [N-1:0]     frame_t;

  typedef struct packed {
    data_t lo;
    data_t hi;
  } pair_t;

  function automatic pair_t cmp_swap(input data_t a, input data_t b);
    pair_t p;
    if (b < a) begin
      p.lo = b;
      p.hi = a;
    end else begin
      p.lo = a;
      p.hi = b;
    end
    return p;
  endfunction
endpackage

// File: rtl/pipe_sorter_sort_layer.sv
// One combinational layer of an odd-even transposition network.
//   ODD=1 : compare-exchange pairs (0,1),(2,3),...
//   ODD=0 : compare-exchange pairs (1,2),(3,4),...; ends pass through
// Ports:
//   frame_i : input frame
//   frame_o : frame after this layer, min of each pair at the lower index
module sort_layer
  import pipe_sorter_pkg::*;
#(
  parameter bit ODD = 1'b1
) (
  input  frame_t frame_i,
  output frame_t frame_o
);
  localparam int FIRST = ODD ? 0 : 1;

  always_comb begin
    pair_t p;
    p       = '0;
    frame_o = frame_i;
    for (int k = FIRST; k < N-1; k += 2) begin
      p            = cmp_swap(frame_i[k], frame_i[k+1]);
      frame_o[k]   = p.lo;
      frame_o[k+1] = p.hi;
    end
  end
endmodule

// File: rtl/pipe_sorter.sv
// Streaming frame sorter: groups every N consecutive samples into a frame,
// sorts it ascending through N registered odd-even transposition layers and
// re-serializes the sorted frame one sample per clock.
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   data_in        : input sample, taken every edge while out of reset
//   data_out       : sorted sample (holds last value when idle)
//   data_out_valid : data_out carries a sorted-frame sample
module pipe_sorter
  import pipe_sorter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid
);
  // ---------------- capture ----------------
  logic [CNT_W-1:0] cnt_q;
  data_t [N-2:0]    buf_q;
  logic             launch;
  frame_t           launch_frame;

  // The last element bypasses the buffer and goes straight into layer 1.
  assign launch       = (cnt_q == CNT_W'(N-1));
  assign launch_frame = {data_in, buf_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      if (launch) cnt_q <= '0;
      else        cnt_q <= cnt_q + 1'b1;
      for (int k = 0; k < N-1; k++)
        if (!launch && cnt_q == CNT_W'(k)) buf_q[k] <= data_in;
    end
  end

  // ---------------- sort pipeline ----------------
  frame_t       lay_in  [1:N];
  frame_t       lay_out [1:N];
  frame_t       stg_q   [1:N];
  logic [N:1]   vld_pipe_q;

  always_comb begin
    lay_in[1] = launch_frame;
    for (int i = 2; i <= N; i++) lay_in[i] = stg_q[i-1];
  end

  for (genvar gi = 1; gi <= N; gi++) begin : g_layer
    sort_layer #(.ODD(gi % 2 == 1)) u_layer (
      .frame_i (lay_in[gi]),
      .frame_o (lay_out[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= N; i++) stg_q[i] <= '0;
      vld_pipe_q <= '0;
    end else begin
      for (int i = 1; i <= N; i++) stg_q[i] <= lay_out[i];
      vld_pipe_q <= {vld_pipe_q[N-1:1], launch};
    end
  end

  // ---------------- serializer ----------------
  data_t            out_q, out_d;
  logic             vld_q, vld_d;
  data_t [N-1:1]    sh_q, sh_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;

  // A new sorted frame lands exactly as the previous one finishes, so the
  // reload branch wins and the stream stays gap-free.
  always_comb begin
    out_d  = out_q;
    vld_d  = 1'b0;
    sh_d   = sh_q;
    ocnt_d = ocnt_q;
    if (vld_pipe_q[N]) begin
      out_d  = stg_q[N][0];
      sh_d   = stg_q[N][N-1:1];
      ocnt_d = CNT_W'(N-1);
      vld_d  = 1'b1;
    end else if (ocnt_q != '0) begin
      out_d  = sh_q[1];
      for (int k = 1; k < N-1; k++) sh_d[k] = sh_q[k+1];
      ocnt_d = ocnt_q - 1'b1;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      vld_q  <= 1'b0;
      sh_q   <= '0;
      ocnt_q <= '0;
    end else begin
      out_q  <= out_d;
      vld_q  <= vld_d;
      sh_q   <= sh_d;
      ocnt_q <= ocnt_d;
    end
  end

  assign data_out       = out_q;
  assign data_out_valid = vld_q;
endmodule

// File: tb/tb_pipe_sorter.sv
// Self-checking bench for pipe_sorter. A reference model collects every N
// inputs since reset, sorts the frame and schedules its elements for the
// edges N..2N-1 after the frame's last edge; every edge is then checked.
module tb_pipe_sorter;
  import pipe_sorter_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  data_t data_in = '0;
  data_t data_out;
  logic  data_out_valid;

  pipe_sorter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  int    t     = 0;          // edge index since reset release
  data_t last_d = '0;
  data_t fr[$];
  data_t exp_d[int];

  data_t fa [8] = '{3, 6, 7, 4, 7, 5, 5, 1};
  data_t fb [8] = '{0, 0, 255, 255, 1, 2, 254, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic step(input data_t d);
    data_in = d;
    @(posedge clk);
    #1;
    fr.push_back(d);
    if (fr.size() == N) begin
      fr.sort();
      foreach (fr[j]) exp_d[t + N + j] = fr[j];
      fr.delete();
    end
    if (exp_d.exists(t)) begin
      chk("valid", 32'(data_out_valid), 32'd1);
      chk("data", 32'(data_out), 32'(exp_d[t]));
      last_d = exp_d[t];
      exp_d.delete(t);
    end else begin
      chk("idle_valid", 32'(data_out_valid), 32'd0);
      chk("idle_hold", 32'(data_out), 32'(last_d));
    end
    t++;
  endtask

  task automatic do_reset(input int cyc);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    repeat (cyc) begin
      @(posedge clk);
      #1;
      chk("rst_valid", 32'(data_out_valid), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
    end
    rst_n = 1'b1;
    fr.delete();
    exp_d.delete();
    t      = 0;
    last_d = '0;
  endtask

  initial begin
    #2;
    do_reset(15);

    // first frame, then reset at element 4 of the next: nothing may come out
    foreach (fa[i]) step(fa[i]);
    repeat (4) step(data_t'($urandom));
    do_reset(4);

    // directed frames, back to back
    foreach (fa[i]) step(fa[i]);
    for (int i = 8; i >= 1; i--) step(data_t'(i));
    foreach (fb[i]) step(fb[i]);
    repeat (8) step(data_t'(42));
    for (int i = 0; i < 8; i++) step(data_t'(i));
    for (int i = 7; i >= 0; i--) step(data_t'(i));

    // random frames
    repeat (1000 * N) step(data_t'($urandom));

    // reset while the last frames are serializing
    repeat (N + 3) step(data_t'($urandom));
    do_reset(3);

    // full frame after release, drained
    foreach (fa[i]) step(fa[i]);
    repeat (2 * N) step(data_t'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
